approx_err_monitor: RTL and testbench
=====================================

Name: approx_err_monitor

Overview:
- Downstream consumer of the 16-bit approximate and exact parallel-prefix adders.
- Receives paired exact/approximate results (sum plus carry-out) through a valid/ready handshake over a programmed batch of N samples.
- Accumulates error metrics: erroneous-result count, sum of error distance (ED) and maximum ED.
- Error rate and mean ED are derived by software/bench from the outputs.

Parameters:
- WIDTH, 16, adder operand width; results are WIDTH+1 bits (carry-out is the MSB).
- CNT_W, 32, width of the sample and error counters and of num_samples.
- ACC_W, 48, width of the ED accumulator.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a batch (accepted in IDLE and DONE only).
- num_samples  input  CNT_W  batch length N; sampled on the accepted start.
- in_valid  input  1  result pair valid.
- in_ready  output  1  block can accept a pair.
- exact_res  input  WIDTH+1  exact adder {Cout, Sum}.
- approx_res  input  WIDTH+1  approximate adder {Cout, Sum}.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; results stable.
- sample_count  output  CNT_W  pairs accepted this batch.
- err_count  output  CNT_W  pairs with exact_res != approx_res.
- ed_sum  output  ACC_W  sum of |exact_res - approx_res|, saturating.
- max_ed  output  WIDTH+1  largest ED seen.
- ed_sat  output  1  ed_sum has saturated this batch (sticky).

Behaviour:
- Reset: state IDLE; in_ready, busy, done, ed_sat = 0; all counters and accumulators = 0; pipeline valid = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Clear sample_count, err_count, ed_sum, max_ed, ed_sat.
  - Latch N.
  - N == 0: go directly to DONE on the next cycle with all outputs 0.
  - Otherwise go to RUN.
- start while in RUN/DRAIN is ignored.
- RUN:
  - in_ready = 1 (registered, asserted the cycle after entry).
  - A transfer occurs when in_valid && in_ready.
  - Each transfer increments sample_count and loads pipeline stage 1.
- Stage 1 (registered):
  - ED = |exact_res - approx_res|, computed as an unsigned WIDTH+1-bit magnitude (larger minus smaller; no wrap).
  - mismatch = (ED != 0).
- Stage 2 (registered, one cycle after stage 1):
  - err_count += mismatch.
  - ed_sum += ED, saturating at 2^ACC_W-1 and setting ed_sat.
  - max_ed = max(max_ed, ED).
- Transfer number N:
  - in_ready drops in the following cycle; no further transfer is accepted.
  - FSM enters DRAIN.
- DRAIN: held until the stage-1 and stage-2 valids are both clear (2 cycles).
- DONE:
  - Entered after DRAIN; done = 1 and all result outputs hold until the next start.
  - done is asserted 3 cycles after the clock edge of the last transfer.
- Upstream stall: in_valid low in RUN leaves all state unchanged.
- The upstream side must hold data stable while in_valid && !in_ready.
- Counters:
  - sample_count never exceeds N.
  - err_count <= sample_count.
  - Neither counter wraps within a batch.
- Reset mid-batch returns immediately to the reset values; the partial batch is discarded.
- Throughput is one pair per cycle, sustained.

Test Plan:
- Reset, then start with N=4. Pairs (exact,approx): (375,371), (31,31), (10,12), (11,11), in_valid held high. Required: done 3 cycles after the 4th transfer; sample_count=4, err_count=2, ed_sum=6, max_ed=4, ed_sat=0.
- N=0 start: done=1 one cycle later, in_ready never asserted, all results 0.
- Back-pressure and stalls: N=3 with in_valid toggling 1,0,0,1,0,1 and a 4th pair offered after the 3rd transfer. Required: 4th pair not accepted (in_ready=0), sample_count=3.
- ED at the extremes: (0x1FFFF,0) and (0,0x1FFFF), N=2. Required: max_ed=0x1FFFF, ed_sum=0x3FFFE, err_count=2.
- Saturation (bench built with ACC_W=17): same two pairs as the ED-extremes case. Required: ed_sum=0x1FFFF, ed_sat=1.
- Pulse rst_n low mid-RUN after 2 transfers. Required: all outputs 0 immediately, state IDLE. A new start with N=1, pair (20,20): sample_count=1, err_count=0.

Source files
------------

// File: rtl/approx_err_monitor.sv
// Error-metric monitor for approximate adders.
// Accepts exact/approximate result pairs over a valid/ready handshake for a
// programmed batch of N samples and accumulates the erroneous-result count,
// the saturating sum of error distances and the maximum error distance.
module approx_err_monitor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   exact_res,
    input  logic [WIDTH:0]   approx_res,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] ed_sum,
    output logic [WIDTH:0]   max_ed,
    output logic             ed_sat
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_num;
    logic               r_in_ready;
    logic [CNT_W-1:0]   r_sample_count;
    logic [CNT_W-1:0]   r_err_count;
    logic [ACC_W-1:0]   r_ed_sum;
    logic [WIDTH:0]     r_max_ed;
    logic               r_ed_sat;
    logic               r_s1_vld;
    logic [WIDTH:0]     r_s1_ed;
    logic               r_s2_vld;

    logic               w_xfer;
    logic               w_start_ok;
    logic               w_last;
    logic [WIDTH:0]     w_ed;
    logic [ACC_W:0]     w_sum;

    assign w_xfer     = in_valid && r_in_ready;
    assign w_start_ok = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_last     = w_xfer && ((r_sample_count + CNT_W'(1)) == r_num);
    // Magnitude as larger minus smaller, so the difference never wraps.
    assign w_ed       = (exact_res >= approx_res) ? (exact_res - approx_res)
                                                  : (approx_res - exact_res);
    // One extra bit catches accumulator overflow for saturation.
    assign w_sum      = {1'b0, r_ed_sum} + {{(ACC_W - WIDTH){1'b0}}, r_s1_ed};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_nxt = (num_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (!r_s1_vld && !r_s2_vld) begin
                    w_state_nxt = StDone;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Batch control: latch N, registered ready, accepted-sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num          <= '0;
            r_in_ready     <= 1'b0;
            r_sample_count <= '0;
        end else if (w_start_ok) begin
            r_num          <= num_samples;
            r_in_ready     <= (num_samples != '0);
            r_sample_count <= '0;
        end else begin
            if (w_last) begin
                r_in_ready <= 1'b0;
            end
            if (w_xfer) begin
                r_sample_count <= r_sample_count + CNT_W'(1);
            end
        end
    end

    // Stage 1: register the error distance of each accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_ed  <= '0;
        end else begin
            r_s1_vld <= w_xfer;
            if (w_xfer) begin
                r_s1_ed <= w_ed;
            end
        end
    end

    // Stage 2: fold the stage-1 distance into the batch metrics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld    <= 1'b0;
            r_err_count <= '0;
            r_ed_sum    <= '0;
            r_max_ed    <= '0;
            r_ed_sat    <= 1'b0;
        end else if (w_start_ok) begin
            r_s2_vld    <= 1'b0;
            r_err_count <= '0;
            r_ed_sum    <= '0;
            r_max_ed    <= '0;
            r_ed_sat    <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                if (r_s1_ed != '0) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
                if (w_sum[ACC_W]) begin
                    r_ed_sum <= '1;
                    r_ed_sat <= 1'b1;
                end else begin
                    r_ed_sum <= w_sum[ACC_W-1:0];
                end
                if (r_s1_ed > r_max_ed) begin
                    r_max_ed <= r_s1_ed;
                end
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = (r_state == StRun) || (r_state == StDrain);
    assign done         = (r_state == StDone);
    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign ed_sum       = r_ed_sum;
    assign max_ed       = r_max_ed;
    assign ed_sat       = r_ed_sat;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor: a default instance plus a second
// instance with a 17-bit accumulator to exercise ED saturation.
module tb_approx_err_monitor;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned ACC_W = 48;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic [WIDTH:0]   exact_res;
    logic [WIDTH:0]   approx_res;

    logic             in_ready, busy, done, ed_sat;
    logic [CNT_W-1:0] sample_count, err_count;
    logic [ACC_W-1:0] ed_sum;
    logic [WIDTH:0]   max_ed;

    logic             in_ready2, busy2, done2, ed_sat2;
    logic [CNT_W-1:0] sample_count2, err_count2;
    logic [16:0]      ed_sum2;
    logic [WIDTH:0]   max_ed2;

    int n_checks = 0;
    int n_errors = 0;

    approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .exact_res    (exact_res),
        .approx_res   (approx_res),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .ed_sum       (ed_sum),
        .max_ed       (max_ed),
        .ed_sat       (ed_sat)
    );

    approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(17)) u_dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .exact_res    (exact_res),
        .approx_res   (approx_res),
        .busy         (busy2),
        .done         (done2),
        .sample_count (sample_count2),
        .err_count    (err_count2),
        .ed_sum       (ed_sum2),
        .max_ed       (max_ed2),
        .ed_sat       (ed_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
    endtask

    // Offer a pair and hold it until it is accepted (bounded).
    task automatic send(input logic [WIDTH:0] e, input logic [WIDTH:0] a);
        bit got_it = 0;
        in_valid   = 1'b1;
        exact_res  = e;
        approx_res = a;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                got_it = 1;
                break;
            end
            tick();
        end
        if (!got_it) check("xfer_timeout", 64'(got_it), 64'd1);
    endtask

    task automatic cyc(input logic v, input logic [WIDTH:0] e, input logic [WIDTH:0] a);
        in_valid   = v;
        exact_res  = e;
        approx_res = a;
        tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            tick();
        end
        check("done_wait", 64'(done), 64'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        num_samples = '0;
        in_valid    = 1'b0;
        exact_res   = '0;
        approx_res  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_samples", 64'(sample_count), 64'd0);
        check("rst_edsum", 64'(ed_sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic batch of four with in_valid held high.
        start_batch(32'd4);
        check("t1_busy", 64'(busy), 64'd1);
        send(17'd375, 17'd371);
        send(17'd31, 17'd31);
        send(17'd10, 17'd12);
        send(17'd11, 17'd11);
        in_valid = 1'b0;
        check("t1_ready_drop", 64'(in_ready), 64'd0);
        check("t1_done_c0", 64'(done), 64'd0);
        tick();
        check("t1_done_c1", 64'(done), 64'd0);
        tick();
        check("t1_done_c2", 64'(done), 64'd0);
        tick();
        check("t1_done_c3", 64'(done), 64'd1);
        check("t1_samples", 64'(sample_count), 64'd4);
        check("t1_errs", 64'(err_count), 64'd2);
        check("t1_edsum", 64'(ed_sum), 64'd6);
        check("t1_maxed", 64'(max_ed), 64'd4);
        check("t1_sat", 64'(ed_sat), 64'd0);
        check("t1_busy_end", 64'(busy), 64'd0);

        // Empty batch.
        start_batch(32'd0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_ready", 64'(in_ready), 64'd0);
        check("t2_samples", 64'(sample_count), 64'd0);
        check("t2_errs", 64'(err_count), 64'd0);
        check("t2_edsum", 64'(ed_sum), 64'd0);
        check("t2_maxed", 64'(max_ed), 64'd0);
        tick();
        check("t2_ready_later", 64'(in_ready), 64'd0);

        // Stalls and a surplus pair offered after the batch is full.
        start_batch(32'd3);
        cyc(1'b1, 17'd100, 17'd90);
        check("t3_cnt_a", 64'(sample_count), 64'd1);
        cyc(1'b0, 17'd5, 17'd5);
        cyc(1'b0, 17'd5, 17'd5);
        check("t3_cnt_stall", 64'(sample_count), 64'd1);
        cyc(1'b1, 17'd5, 17'd5);
        check("t3_cnt_b", 64'(sample_count), 64'd2);
        cyc(1'b0, 17'd0, 17'd7);
        cyc(1'b1, 17'd0, 17'd7);
        check("t3_cnt_c", 64'(sample_count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 17'd55, 17'd44);
            check("t3_extra_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        wait_done();
        check("t3_samples", 64'(sample_count), 64'd3);
        check("t3_errs", 64'(err_count), 64'd2);
        check("t3_edsum", 64'(ed_sum), 64'd17);
        check("t3_maxed", 64'(max_ed), 64'd10);

        // ED extremes; the 17-bit-accumulator instance saturates.
        start_batch(32'd2);
        send(17'h1FFFF, 17'h0);
        send(17'h0, 17'h1FFFF);
        in_valid = 1'b0;
        wait_done();
        check("t4_maxed", 64'(max_ed), 64'h1FFFF);
        check("t4_edsum", 64'(ed_sum), 64'h3FFFE);
        check("t4_errs", 64'(err_count), 64'd2);
        check("t4_sat", 64'(ed_sat), 64'd0);
        check("t5_done", 64'(done2), 64'd1);
        check("t5_edsum", 64'(ed_sum2), 64'h1FFFF);
        check("t5_sat", 64'(ed_sat2), 64'd1);

        // Reset in the middle of a batch.
        start_batch(32'd5);
        send(17'd1, 17'd2);
        send(17'd3, 17'd3);
        in_valid = 1'b0;
        check("t6_pre_cnt", 64'(sample_count), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t6_samples", 64'(sample_count), 64'd0);
        check("t6_errs", 64'(err_count), 64'd0);
        check("t6_edsum", 64'(ed_sum), 64'd0);
        check("t6_maxed", 64'(max_ed), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ready", 64'(in_ready), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_idle_busy", 64'(busy), 64'd0);
        start_batch(32'd1);
        send(17'd20, 17'd20);
        in_valid = 1'b0;
        wait_done();
        check("t7_samples", 64'(sample_count), 64'd1);
        check("t7_errs", 64'(err_count), 64'd0);
        check("t7_edsum", 64'(ed_sum), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
